// File: rtl/row_mem_ctrl_pkg.sv
// row_mem_ctrl_pkg
// Shared types and constants for the debayer row-memory sequencer.
//   state_t         : controller states (IDLE, ACTIVE, GAP, FLUSH, DONE)
//   FLUSH_MIN_LINES : stored lines needed before reads / a flush line are useful
package row_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACTIVE = 3'd1,
        GAP    = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // One buffered line is enough to give the window a previous row.
    localparam int unsigned FLUSH_MIN_LINES = 1;

endpackage

// File: rtl/row_mem_ctrl_rot.sv
// row_rot
// One-hot rotator selecting the row buffer currently being written.
// Ports:
//   sclk    : clock
//   rst     : synchronous active-high reset, returns to row 0
//   advance : rotate left one position (wrapping) at the next edge
//   row     : one-hot newest row
module row_rot
    import row_mem_ctrl_pkg::*;
#(
    parameter int NUM_ROWS = 3
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                advance,
    output logic [NUM_ROWS-1:0] row
);

    always_ff @(posedge sclk) begin
        if (rst)
            row <= NUM_ROWS'(1);
        else if (advance)
            row <= {row[NUM_ROWS-2:0], row[NUM_ROWS-1]};
    end

endmodule

// File: rtl/row_mem_ctrl.sv
// row_mem_ctrl
// Sequences the debayer row memories behind the pixel input FIFO: rotates
// line writes across NUM_ROWS row buffers, issues a common read address for
// the 3x3 window, and replays one flush line at frame end.
// Ports:
//   sclk, rst          : clock, synchronous active-high reset
//   in_frame_valid     : frame valid from pixel fifo
//   in_line_valid      : one pixel per cycle while high
//   in_pixel_data      : pixel
//   wr_en/wr_addr/wr_data : registered row write (one-hot row enable)
//   rd_en/rd_addr      : read all rows at rd_addr
//   newest_row         : one-hot row being written or flushed
//   out_frame_valid    : window stream frame valid
//   out_line_valid     : window column valid (rd_en delayed one cycle)
//   line_width         : width latched from the first line of the frame
//   overflow           : sticky, a line exceeded MAX_WIDTH
//   frame_lines, frame_cnt : only with ROW_MEM_CTRL_STATS_EN defined
module row_mem_ctrl
    import row_mem_ctrl_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int NUM_ROWS  = 3,
    parameter int ADDR_W    = 11,
    parameter int MAX_WIDTH = 2047
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                in_frame_valid,
    input  logic                in_line_valid,
    input  logic [DATA_W-1:0]   in_pixel_data,
    output logic [NUM_ROWS-1:0] wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [NUM_ROWS-1:0] newest_row,
    output logic                out_frame_valid,
    output logic                out_line_valid,
    output logic [ADDR_W:0]     line_width,
    output logic                overflow
`ifdef ROW_MEM_CTRL_STATS_EN
    ,
    output logic [15:0]         frame_lines,
    output logic [15:0]         frame_cnt
`endif
);

    localparam int LC_W = $clog2(NUM_ROWS + 1);
    localparam logic [LC_W-1:0] LC_MAX    = LC_W'(NUM_ROWS);
    localparam logic [LC_W-1:0] LC_ONE    = LC_W'(1);
    localparam logic [LC_W-1:0] FLUSH_MIN = LC_W'(FLUSH_MIN_LINES);
    localparam logic [ADDR_W:0] COL_MAX   = (ADDR_W+1)'(MAX_WIDTH);
    localparam logic [ADDR_W:0] COL_ONE   = (ADDR_W+1)'(1);

    state_t          state;
    logic            fv_d;
    logic            in_line;     // at least one pixel of the current line seen
    logic            first_line;
    logic [LC_W-1:0] line_cnt;
    logic [ADDR_W:0] col;

    logic line_end, pix_ok, have_rows, frame_start;

    assign line_end    = (state == ACTIVE) && in_line && !in_line_valid;
    assign pix_ok      = ((state == ACTIVE) || (state == GAP)) && in_line_valid;
    assign have_rows   = (line_cnt >= FLUSH_MIN);
    assign frame_start = (state == IDLE) && in_frame_valid && !fv_d;

    row_rot #(.NUM_ROWS(NUM_ROWS)) u_rot (
        .sclk    (sclk),
        .rst     (rst),
        .advance (line_end),
        .row     (newest_row)
    );

    always_ff @(posedge sclk) begin
        if (rst) begin
            state           <= IDLE;
            fv_d            <= 1'b0;
            in_line         <= 1'b0;
            first_line      <= 1'b0;
            line_cnt        <= '0;
            col             <= '0;
            wr_en           <= '0;
            wr_addr         <= '0;
            wr_data         <= '0;
            rd_en           <= 1'b0;
            rd_addr         <= '0;
            out_frame_valid <= 1'b0;
            out_line_valid  <= 1'b0;
            line_width      <= '0;
            overflow        <= 1'b0;
        end else begin
            fv_d           <= in_frame_valid;
            wr_en          <= '0;
            rd_en          <= 1'b0;
            out_line_valid <= rd_en;

            // Pixel path: write the newest row and read all rows at the same column.
            if (pix_ok) begin
                in_line <= 1'b1;
                if (col < COL_MAX) begin
                    wr_en   <= newest_row;
                    wr_addr <= col[ADDR_W-1:0];
                    wr_data <= in_pixel_data;
                    col     <= col + COL_ONE;
                    if (have_rows) begin
                        rd_en           <= 1'b1;
                        rd_addr         <= col[ADDR_W-1:0];
                        out_frame_valid <= 1'b1;
                    end
                end else begin
                    overflow <= 1'b1;   // col stays saturated, pixel dropped
                end
            end

            case (state)
                IDLE: begin
                    out_frame_valid <= 1'b0;
                    if (frame_start) begin
                        state      <= ACTIVE;
                        line_cnt   <= '0;
                        col        <= '0;
                        overflow   <= 1'b0;
                        first_line <= 1'b1;
                        in_line    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (line_end) begin
                        in_line <= 1'b0;
                        col     <= '0;
                        if (line_cnt != LC_MAX)
                            line_cnt <= line_cnt + LC_ONE;
                        if (first_line) begin
                            line_width <= col;
                            first_line <= 1'b0;
                        end
                        // Frame may close on the same cycle as the line.
                        state <= in_frame_valid ? GAP : FLUSH;
                    end else if (!in_line && !in_line_valid && !in_frame_valid) begin
                        state <= have_rows ? FLUSH : IDLE;
                    end
                end
                GAP: begin
                    if (in_line_valid)
                        state <= ACTIVE;
                    else if (!in_frame_valid)
                        state <= have_rows ? FLUSH : IDLE;
                end
                FLUSH: begin
                    rd_en           <= 1'b1;
                    rd_addr         <= col[ADDR_W-1:0];
                    out_frame_valid <= 1'b1;
                    col             <= col + COL_ONE;
                    if (col + COL_ONE >= line_width) begin
                        col   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // out_frame_valid holds over the last out_line_valid, drops in IDLE.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROW_MEM_CTRL_STATS_EN
    logic [15:0] lines_seen;

    always_ff @(posedge sclk) begin
        if (rst) begin
            lines_seen  <= '0;
            frame_lines <= '0;
            frame_cnt   <= '0;
        end else begin
            if (frame_start)
                lines_seen <= '0;
            else if (line_end)
                lines_seen <= lines_seen + 16'd1;
            if (state == DONE) begin
                frame_lines <= lines_seen;
                frame_cnt   <= frame_cnt + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
